// File: rtl/isa_defs.sv
// isa_defs: opcode/aluop encodings, field positions, exception codes and MD state encoding.
package isa_defs;
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int IMM_W     = 17;

    localparam logic [4:0] RSTATUS = 5'd30;

    localparam logic [2:0] EXC_ADD  = 3'd1;
    localparam logic [2:0] EXC_ADDI = 3'd2;
    localparam logic [2:0] EXC_SUB  = 3'd3;
    localparam logic [2:0] EXC_MUL  = 3'd4;
    localparam logic [2:0] EXC_DIV  = 3'd5;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    function automatic logic [31:0] sext17(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction
endpackage

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (radix-2 Booth) and divide (non-restoring on magnitudes).
module multdiv_unit
    import isa_defs::*;
#(
    parameter int W         = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         exception
);
    localparam int CW = MD_CYCLES > 1 ? $clog2(MD_CYCLES) : 1;

    md_state_t      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d, booth_acc;
    logic [W+1:0]   rem_q, rem_d, rem_sh, rem_new;
    logic [W-1:0]   m_q, m_d, res_q, res_d, mag_a, mag_b, quo;
    logic [W:0]     booth_sum;
    logic           q1_q, q1_d, div_q, div_d, neg_q, neg_d, dz_q, dz_d, exc_q, exc_d;

    always_comb begin
        mag_a     = op_a[W-1] ? -op_a : op_a;
        mag_b     = op_b[W-1] ? -op_b : op_b;
        // Upper half kept one bit wider so subtracting the most negative multiplicand cannot wrap
        booth_sum = {acc_q[2*W-1], acc_q[2*W-1:W]} +
                    (acc_q[0] == q1_q ? '0 : acc_q[0] ? -{m_q[W-1], m_q} : {m_q[W-1], m_q});
        booth_acc = {booth_sum, acc_q[W-1:1]};
        rem_sh    = {rem_q[W:0], acc_q[W-1]};
        rem_new   = rem_q[W+1] ? rem_sh + {2'b00, m_q} : rem_sh - {2'b00, m_q};
        quo       = {acc_q[W-2:0], ~rem_new[W+1]};
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        m_d       = m_q;
        q1_d      = q1_q;
        div_d     = div_q;
        neg_d     = neg_q;
        dz_d      = dz_q;
        res_d     = res_q;
        exc_d     = exc_q;
        case (state_q)
            MD_IDLE: if (start) begin
                state_d = MD_BUSY;
                cnt_d   = '0;
                div_d   = is_div;
                q1_d    = 1'b0;
                rem_d   = '0;
                neg_d   = op_a[W-1] ^ op_b[W-1];
                dz_d    = op_b == '0;
                acc_d   = {{W{1'b0}}, is_div ? mag_a : op_a};
                m_d     = is_div ? mag_b : op_b;
            end
            MD_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = div_q ? {acc_q[2*W-1:W], quo} : booth_acc;
                q1_d  = acc_q[0];
                rem_d = rem_new;
                if (cnt_q == CW'(MD_CYCLES - 1)) begin
                    state_d = MD_DONE;
                    res_d   = div_q ? (dz_q ? '0 : neg_q ? -quo : quo) : booth_acc[W-1:0];
                    exc_d   = div_q ? dz_q : booth_acc[2*W-1:W] != {W{booth_acc[W-1]}};
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    assign busy      = rst_n && ((state_q == MD_IDLE && start) || state_q == MD_BUSY);
    assign done      = state_q == MD_DONE;
    assign result    = res_q;
    assign exception = exc_q;
endmodule

// File: rtl/execute_stage.sv
// execute_stage: X stage with ALU, operand bypass, branch resolution and the iterative mul/div unit.
module execute_stage
    import isa_defs::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      dx_pc,
    input  logic [31:0]      dx_insn,
    input  logic [WIDTH-1:0] dx_a,
    input  logic [WIDTH-1:0] dx_b,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [WIDTH-1:0] xm_result,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] x_result,
    output logic [31:0]      x_insn,
    output logic [WIDTH-1:0] x_store,
    output logic             branch_taken,
    output logic [31:0]      branch_target,
    output logic             stall
);
    logic [4:0]       opcode, aluop, shamt;
    logic [WIDTH-1:0] op_a, op_b, imm, sum, diff, addi_sum, md_result, res;
    logic             is_mul, is_div, add_ovf, sub_ovf, addi_ovf, md_busy, md_done, md_exc, exc, br_cond;
    logic [2:0]       code;

    assign opcode   = dx_insn[OPC_LSB +: 5];
    assign aluop    = dx_insn[ALUOP_LSB +: 5];
    assign shamt    = dx_insn[SHAMT_LSB +: 5];
    assign imm      = WIDTH'(sext17(dx_insn[IMM_W-1:0]));
    assign op_a     = fwd_a_sel == 2'd1 ? xm_result : fwd_a_sel == 2'd2 ? wb_data : dx_a;
    assign op_b     = fwd_b_sel == 2'd1 ? xm_result : fwd_b_sel == 2'd2 ? wb_data : dx_b;
    assign sum      = op_a + op_b;
    assign diff     = op_a - op_b;
    assign addi_sum = op_a + imm;
    assign add_ovf  = op_a[WIDTH-1] == op_b[WIDTH-1] && sum[WIDTH-1] != op_a[WIDTH-1];
    assign sub_ovf  = op_a[WIDTH-1] != op_b[WIDTH-1] && diff[WIDTH-1] != op_a[WIDTH-1];
    assign addi_ovf = op_a[WIDTH-1] == imm[WIDTH-1] && addi_sum[WIDTH-1] != op_a[WIDTH-1];
    assign is_mul   = opcode == OP_RTYPE && aluop == ALU_MUL;
    assign is_div   = opcode == OP_RTYPE && aluop == ALU_DIV;

    multdiv_unit #(.W(WIDTH), .MD_CYCLES(MD_CYCLES)) u_md (
        .clk      (clock),
        .rst_n    (reset),
        .start    (is_mul || is_div),
        .is_div   (is_div),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (md_busy),
        .done     (md_done),
        .result   (md_result),
        .exception(md_exc)
    );

    always_comb begin
        res  = '0;
        exc  = 1'b0;
        code = EXC_ADD;
        if (md_done) begin
            res  = md_result;
            exc  = md_exc;
            code = is_div ? EXC_DIV : EXC_MUL;
        end else if (opcode == OP_RTYPE) begin
            case (aluop)
                ALU_ADD: begin res = sum;  exc = add_ovf; code = EXC_ADD; end
                ALU_SUB: begin res = diff; exc = sub_ovf; code = EXC_SUB; end
                ALU_AND: res = op_a & op_b;
                ALU_OR:  res = op_a | op_b;
                ALU_SLL: res = op_a << shamt;
                ALU_SRA: res = $signed(op_a) >>> shamt;
                default: res = '0;
            endcase
        end else if (opcode == OP_ADDI) begin
            res  = addi_sum;
            exc  = addi_ovf;
            code = EXC_ADDI;
        end else if (opcode == OP_SW || opcode == OP_LW) begin
            res = addi_sum;
        end
        x_result = exc ? WIDTH'(code) : res;
        x_insn   = exc ? {dx_insn[31:RD_LSB+5], RSTATUS, dx_insn[RD_LSB-1:0]} : dx_insn;
    end

    // Branches arrive with the rd-operand in B and the rs-operand in A
    assign br_cond       = (opcode == OP_BNE && op_a != op_b) ||
                           (opcode == OP_BLT && $signed(op_b) < $signed(op_a));
    assign stall         = md_busy;
    assign branch_taken  = reset && !stall && br_cond;
    assign branch_target = dx_pc + sext17(dx_insn[IMM_W-1:0]);
    assign x_store       = op_b;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized scoreboard bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dx_pc, dx_insn, dx_a, dx_b, xm_result, wb_data;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] x_result, x_insn, x_store, branch_target;
    logic        branch_taken, stall;

    execute_stage dut (
        .clock        (clock),
        .reset        (reset),
        .dx_pc        (dx_pc),
        .dx_insn      (dx_insn),
        .dx_a         (dx_a),
        .dx_b         (dx_b),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .xm_result    (xm_result),
        .wb_data      (wb_data),
        .x_result     (x_result),
        .x_insn       (x_insn),
        .x_store      (x_store),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res, insn, store, tgt;
        logic        br, chk_res, chk_store;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] rtype(input int fn, input int rd, input int rs, input int rt, input int sh);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(fn), 2'b00};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rd, input int rs, input logic [16:0] imm);
        return {5'(op), 5'(rd), 5'(rs), imm};
    endfunction

    // Reference: plain 64-bit signed arithmetic; overflow is an out-of-range 32-bit result
    function automatic exp_t model(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc);
        exp_t       e;
        longint     sa, sb, si, r;
        int         code;
        logic       dz;
        logic [4:0] op, fn, sh;
        op = insn[31:27];
        fn = insn[6:2];
        sh = insn[11:7];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        si = longint'($signed(insn[16:0]));
        e.insn = insn;
        e.store = b;
        e.tgt = pc + si[31:0];
        e.br = 1'b0;
        e.chk_res = 1'b1;
        e.chk_store = 1'b1;
        e.stalls = 0;
        r = 0;
        code = 0;
        dz = 1'b0;
        if (op == 5'd0) begin
            case (fn)
                5'd0: begin r = sa + sb; code = 1; end
                5'd1: begin r = sa - sb; code = 3; end
                5'd2: r = a & b;
                5'd3: r = a | b;
                5'd4: r = a << sh;
                5'd5: r = sa >>> sh;
                5'd6: begin r = sa * sb; code = 4; e.stalls = 33; e.chk_store = 1'b0; end
                5'd7: begin
                    e.stalls = 33;
                    e.chk_store = 1'b0;
                    if (b == 0) dz = 1'b1;
                    else r = sa / sb;
                end
                default: r = 0;
            endcase
        end else if (op == 5'd5) begin
            r = sa + si;
            code = 2;
        end else if (op == 5'd7 || op == 5'd8) begin
            r = sa + si;
        end else if (op == 5'd2) begin
            e.br = a != b;
            e.chk_res = 1'b0;
        end else if (op == 5'd6) begin
            e.br = sb < sa;
            e.chk_res = 1'b0;
        end
        if (dz || (code != 0 && (r < -64'sd2147483648 || r > 64'sd2147483647))) begin
            e.res = dz ? 32'd5 : 32'(code);
            e.insn = {insn[31:27], 5'd30, insn[21:0]};
        end else begin
            e.res = r[31:0];
        end
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && !stall && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_res) check("x_result", x_result, e.res);
                check("x_insn", x_insn, e.insn);
                if (e.chk_store) check("x_store", x_store, e.store);
                check("branch_taken", {31'b0, branch_taken}, {31'b0, e.br});
                check("branch_target", branch_target, e.tgt);
            end
        end
    end

    task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] xm, input logic [31:0] wb);
        exp_t        e;
        logic [31:0] ea, eb;
        int          n;
        @(posedge clock);
        #1;
        dx_insn = insn;
        dx_a = a;
        dx_b = b;
        fwd_a_sel = fa;
        fwd_b_sel = fb;
        xm_result = xm;
        wb_data = wb;
        dx_pc = $urandom;
        ea = fa == 2'd1 ? xm : fa == 2'd2 ? wb : a;
        eb = fb == 2'd1 ? xm : fb == 2'd2 ? wb : b;
        e = model(insn, ea, eb, dx_pc);
        exp_q.push_back(e);
        n = 0;
        @(negedge clock);
        while (stall && n < 100) begin
            n++;
            // operands were captured at the first edge; later changes must not matter
            if (n >= 2) begin
                dx_a = $urandom;
                dx_b = $urandom;
                xm_result = $urandom;
                wb_data = $urandom;
            end
            @(negedge clock);
        end
        check("stall_cycles", 32'(n), 32'(e.stalls));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] insn;
        int          k;
        reset = 1'b0;
        dx_pc = 32'd100;
        dx_insn = rtype(6, 1, 2, 3, 0);
        dx_a = -32'sd3;
        dx_b = 32'd7;
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        xm_result = 32'd0;
        wb_data = 32'd0;
        #3 check("rst_stall", {31'b0, stall}, 32'd0);
        dx_insn = itype(6, 1, 2, 17'd8);
        dx_a = 32'd0;
        dx_b = 32'hFFFFFFFF;
        #1 check("rst_branch", {31'b0, branch_taken}, 32'd0);
        dx_insn = rtype(0, 3, 1, 2, 0);
        dx_a = 32'd5;
        dx_b = 32'd7;
        #1 check("rst_add", x_result, 32'd12);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;

        issue(rtype(0, 3, 1, 2, 0), 32'h7FFFFFFF, 32'd1, 0, 0, $urandom, $urandom);
        issue(rtype(0, 3, 1, 2, 0), 32'd5, 32'd7, 0, 0, $urandom, $urandom);
        issue(rtype(1, 4, 1, 2, 0), 32'h80000000, 32'd1, 0, 0, $urandom, $urandom);
        issue(itype(5, 4, 1, 17'd1), 32'h7FFFFFFF, 32'd0, 0, 0, $urandom, $urandom);
        issue(rtype(6, 5, 1, 2, 0), -32'sd3, 32'd7, 0, 0, $urandom, $urandom);
        issue(rtype(6, 5, 1, 2, 0), 32'h10000, 32'h10000, 0, 0, $urandom, $urandom);
        issue(rtype(7, 6, 1, 2, 0), 32'h80000001, 32'd2, 0, 0, $urandom, $urandom);
        issue(rtype(7, 6, 1, 2, 0), 32'd7, 32'd0, 0, 0, $urandom, $urandom);
        issue(rtype(6, 7, 1, 2, 0), 32'd123, -32'sd456, 0, 0, $urandom, $urandom);
        issue(rtype(6, 8, 3, 4, 0), -32'sd77, 32'd99, 0, 0, $urandom, $urandom);

        @(posedge clock);
        #1;
        dx_insn = rtype(6, 4, 1, 2, 0);
        dx_a = -32'sd3;
        dx_b = 32'd7;
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        repeat (11) @(posedge clock);
        #1 check("busy_before_abort", {31'b0, stall}, 32'd1);
        #1 reset = 1'b0;
        #1 check("abort_stall", {31'b0, stall}, 32'd0);
        dx_insn = rtype(0, 0, 0, 0, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        issue(rtype(6, 5, 1, 2, 0), -32'sd3, 32'd7, 0, 0, $urandom, $urandom);

        issue(rtype(0, 3, 1, 2, 0), 32'd1000, 32'd4, 1, 0, 32'd9, $urandom);
        issue(itype(2, 1, 2, 17'd12), 32'd5, 32'd1000, 0, 2, $urandom, 32'd5);
        issue(itype(6, 1, 2, 17'h1FFF0), 32'd0, 32'hFFFFFFFF, 3, 0, $urandom, $urandom);

        repeat (80) begin
            k = $urandom_range(0, 13);
            case (k)
                8:  insn = rtype($urandom_range(8, 31), $urandom, $urandom, $urandom, $urandom);
                9:  insn = itype(5, $urandom, $urandom, 17'($urandom));
                10: insn = itype($urandom_range(7, 8), $urandom, $urandom, 17'($urandom));
                11: insn = itype(2, $urandom, $urandom, 17'($urandom));
                12: insn = itype(6, $urandom, $urandom, 17'($urandom));
                13: insn = itype(9 + $urandom_range(0, 22), $urandom, $urandom, 17'($urandom));
                default: insn = rtype(k, $urandom, $urandom, $urandom, $urandom);
            endcase
            issue(insn, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  rnd_val(), rnd_val());
        end

        repeat (3) @(posedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (X) stage of the five-stage pipeline: consumes the instruction and operands held in the D/X latch and produces the result, store data and control the X/M latch captures. It holds the ALU, operand bypass muxes, branch resolution, and an iterative 32-cycle signed multiply/divide unit. While the multiply/divide unit is busy, the stage stalls the front of the pipeline.

## Interface
Parameters:
- WIDTH, 32, datapath width; the instruction-field positions below assume 32.
- MD_CYCLES, 32, iterations per multiply or divide.

Ports:
- clock  in  1  rising-edge clock, the single clock domain.
- reset  in  1  asynchronous, active-low reset.
- dx_pc  in  32  PC+1 of the instruction in X.
- dx_insn  in  32  instruction from the D/X latch.
- dx_a, dx_b  in  32 each  register operands from the D/X latch.
- fwd_a_sel, fwd_b_sel  in  2 each  bypass select: 0 = dx operand, 1 = xm_result, 2 = wb_data, 3 reserved (treated as 0).
- xm_result, wb_data  in  32 each  bypass sources.
- x_result  out  32  ALU/MD result, or the exception status code.
- x_insn  out  32  instruction passed to X/M; rd is rewritten to 30 on an exception.
- x_store  out  32  bypassed B operand, used as store data.
- branch_taken  out  1  redirect the PC to branch_target this cycle.
- branch_target  out  32  dx_pc + sign-extended imm17.
- stall  out  1  hold the PC, F/D and D/X latches, and insert a bubble into X/M.

## Operation
Instruction fields:
- opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], imm17[16:0].

R-type (opcode 00000), selected by aluop:
- add 00000, sub 00001, and 00010, or 00011.
- sll 00100 and sra 00101 shift by shamt.
- mul 00110 and div 00111 are routed to the MD unit.

Other opcodes:
- addi 00101: A + sext(imm17).
- sw 00111 and lw 01000: address = A + sext(imm17).
- bne 00010: taken when A != B.
- blt 00110: taken when rd-operand < rs-operand, signed.
- Unknown opcodes produce x_result = 0.

Overflow and exception codes:
- add, addi and sub signal overflow on a signed overflow.
- mul signals overflow when product[63:32] is not the sign-extension of product[31].
- div signals overflow on a divisor of 0.
- On any of these: x_insn.rd = 30, and x_result = 1 (add), 2 (addi), 3 (sub), 4 (mul), 5 (div).

MD unit:
- Operands are captured after bypassing.
- mul uses radix-2 Booth with a 64-bit accumulator.
- div uses non-restoring division on magnitudes, with the quotient sign fixed at the end; the remainder is discarded.
- The quotient truncates toward zero. A divisor of 0 gives a quotient of 0 plus the exception.

MD FSM states:
- IDLE: if the instruction is mul or div, capture the operands, counter = 0, stall = 1, then go to BUSY.
- BUSY: one iteration per cycle with stall = 1. When counter = MD_CYCLES-1, go to DONE.
- DONE: stall = 0. x_result and x_insn come from the MD registers. Go to IDLE unconditionally.
- Because DONE always exits to IDLE, the same held instruction is never restarted. A back-to-back mul in the next cycle starts a fresh operation.

## Timing
- ALU, bypass and branch paths are combinational: the result is valid in the same cycle the instruction sits in X.
- MD latency, for a mul/div in X at cycle N:
  - stall is high in cycles N through N+MD_CYCLES.
  - DONE occurs at N+MD_CYCLES+1.
  - X/M captures the result at the end of the DONE cycle.
- branch_taken is never asserted while stall = 1.
- During reset (reset = 0), and on the first edge after it:
  - FSM = IDLE, counter = 0, MD registers = 0.
  - stall = 0, branch_taken = 0.
  - The combinational outputs follow their inputs.
- If reset is asserted mid-operation, the operation is aborted: stall drops immediately (asynchronously) and no result is produced.
- The bypass selects apply in every cycle. The MD unit uses only the operands captured in IDLE; input changes during BUSY are ignored.

## Structure
- Shared package (isa_defs): opcode and aluop constants, field bit positions, exception codes 1–5, the rstatus register index 30, and the MD state encoding.
- One sub-module, multdiv_unit: the FSM, counter and Booth/non-restoring datapath.
  - Inputs: start, is_div, operands.
  - Outputs: busy, done, result, exception.
- The ALU, bypass muxes and branch logic live in execute_stage.

## Test plan
- add: A = 0x7FFFFFFF, B = 1 -> x_result = 1 and x_insn.rd = 30. Repeat with A = 5, B = 7 -> x_result = 12 and rd unchanged.
- mul: A = -3, B = 7 -> stall high for exactly 33 cycles, then x_result = 0xFFFFFFEB for one cycle with stall = 0. Also check mul 0x10000 × 0x10000 -> x_result = 4 and rd = 30.
- div: 0x80000001 / 2 = 0xC0000001. 7 / 0 -> x_result = 5 and rd = 30, after the full latency.
- Back-to-back mul, mul: each takes 33 stall cycles. The second result is independent of the first, and there is no restart in DONE.
- Pull reset low at BUSY count 10 -> stall = 0 asynchronously. After release, the next mul completes correctly.
- Bypass: fwd_a_sel = 1 with xm_result = 9 on add -> uses 9. bne with equal bypassed operands -> branch_taken = 0. blt with -1 < 0 -> branch_taken = 1 and branch_target = dx_pc + imm.
